// File: rtl/llist_buf_allocator_pkg.sv
// ---------------------------------------------------------------------------
// llist_buf_allocator_pkg
//   Shared definitions for the linked-list buffer allocator:
//   - default pool geometry (DEPTH / PTR_W)
//   - FSM state encoding, exported on the allocator's debug port
//   - helper that computes the free-index count from the pool registers
// ---------------------------------------------------------------------------
package llist_buf_allocator_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_PTR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ACK_ALLOC   = 2'd1,
    ST_ACK_DEALLOC = 2'd2
  } state_t;

  // Free indices = never-issued indices plus the ones parked on the free list.
  // All operands are PTR_W+1 bits wide; the result fits because the pool
  // never holds more than DEPTH indices.
  function automatic logic [DEFAULT_PTR_W:0] free_count_f(
    input logic [DEFAULT_PTR_W:0] depth,
    input logic [DEFAULT_PTR_W:0] fresh_ptr,
    input logic [DEFAULT_PTR_W:0] list_cnt
  );
    return (depth - fresh_ptr) + list_cnt;
  endfunction

endpackage

// File: rtl/llist_buf_allocator_if.sv
// ---------------------------------------------------------------------------
// llist_buf_allocator_if
//   Alloc/dealloc request-acknowledge bus between a requester (master) and
//   the buffer allocator (slave).
//
//   Handshake (both channels, 4-phase level protocol):
//     master raises *_req (with dealloc_ptr stable) -> slave raises *_ack
//     with its result fields -> master drops *_req -> slave drops *_ack.
//     Result fields (alloc_ptr/alloc_fail, dealloc_err) are valid while the
//     matching *_ack is high. Only one transaction is in flight at a time;
//     dealloc wins when both requests are high in the same cycle.
//
//   Signals:
//     alloc_req   m->s  allocate request
//     alloc_ack   s->m  allocate acknowledge
//     alloc_ptr   s->m  granted index
//     alloc_fail  s->m  pool exhausted, nothing granted
//     dealloc_req m->s  deallocate request
//     dealloc_ptr m->s  index being returned
//     dealloc_ack s->m  deallocate acknowledge
//     dealloc_err s->m  index was not allocated (double free)
//     free_count  s->m  number of free indices, 0..DEPTH
//     pool_empty  s->m  free_count == 0
// ---------------------------------------------------------------------------
interface llist_buf_allocator_if #(
  parameter int PTR_W = 4
);

  logic             alloc_req;
  logic             alloc_ack;
  logic [PTR_W-1:0] alloc_ptr;
  logic             alloc_fail;
  logic             dealloc_req;
  logic [PTR_W-1:0] dealloc_ptr;
  logic             dealloc_ack;
  logic             dealloc_err;
  logic [PTR_W:0]   free_count;
  logic             pool_empty;

  modport master (
    output alloc_req,
    output dealloc_req,
    output dealloc_ptr,
    input  alloc_ack,
    input  alloc_ptr,
    input  alloc_fail,
    input  dealloc_ack,
    input  dealloc_err,
    input  free_count,
    input  pool_empty
  );

  modport slave (
    input  alloc_req,
    input  dealloc_req,
    input  dealloc_ptr,
    output alloc_ack,
    output alloc_ptr,
    output alloc_fail,
    output dealloc_ack,
    output dealloc_err,
    output free_count,
    output pool_empty
  );

endinterface

// File: rtl/llist_buf_allocator_next_mem.sv
// ---------------------------------------------------------------------------
// llist_buf_allocator_next_mem
//   DEPTH x PTR_W next-pointer array for the free list (also usable by the
//   linked-list FIFO data path). One synchronous write port, one
//   asynchronous read port. Contents are not reset: an entry is only read
//   after it has been written as part of a list link.
//
//   Ports:
//     i_clk    clock
//     i_we     write enable
//     i_waddr  write index
//     i_wdata  next-pointer value to store
//     i_raddr  read index
//     o_rdata  next-pointer stored at i_raddr (combinational)
// ---------------------------------------------------------------------------
module llist_buf_allocator_next_mem #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [PTR_W-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [PTR_W-1:0] o_rdata
);

  logic [PTR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/llist_buf_allocator.sv
// ---------------------------------------------------------------------------
// llist_buf_allocator
//   Owns a pool of DEPTH buffer indices. Grants an index on each alloc
//   request and takes one back on each dealloc request, over a 4-phase
//   request/acknowledge bus.
//
//   The pool is split in two parts:
//     - fresh indices never handed out: r_fresh_ptr .. DEPTH-1
//     - returned indices, kept as a FIFO linked list (r_head, r_tail,
//       r_list_cnt, next-pointer array) pushed at the tail, popped at head
//   Returned indices are reused before fresh ones. An allocation bitmap
//   catches double frees.
//
//   Ports:
//     i_system_clock  clock, rising edge
//     i_reset         synchronous reset, active-high
//     bus             allocator side of llist_buf_allocator_if
//     o_state         FSM state, for debug / checker binding
// ---------------------------------------------------------------------------
module llist_buf_allocator
  import llist_buf_allocator_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = DEFAULT_PTR_W
) (
  input  logic                 i_system_clock,
  input  logic                 i_reset,
  llist_buf_allocator_if.slave bus,
  output state_t               o_state
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

  state_t           r_state;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_list_cnt;
  logic [PTR_W:0]   r_fresh_ptr;
  logic [DEPTH-1:0] r_bitmap;

  logic             r_alloc_ack;
  logic [PTR_W-1:0] r_alloc_ptr;
  logic             r_alloc_fail;
  logic             r_dealloc_ack;
  logic             r_dealloc_err;

  logic             w_dealloc_go;
  logic             w_dealloc_ok;
  logic             w_nm_we;
  logic [PTR_W-1:0] w_nm_rdata;
  logic [PTR_W:0]   w_free_count;

  // A dealloc is accepted in IDLE whenever requested; it only changes the
  // pool when the index is currently allocated.
  assign w_dealloc_go = (r_state == ST_IDLE) && bus.dealloc_req;
  assign w_dealloc_ok = r_bitmap[bus.dealloc_ptr];

  // Link the old tail to the returned index. When the list is empty the
  // returned index becomes both head and tail and no link is needed.
  assign w_nm_we = !i_reset && w_dealloc_go && w_dealloc_ok && (r_list_cnt != '0);

  llist_buf_allocator_next_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_next_mem (
    .i_clk   (i_system_clock),
    .i_we    (w_nm_we),
    .i_waddr (r_tail),
    .i_wdata (bus.dealloc_ptr),
    .i_raddr (r_head),
    .o_rdata (w_nm_rdata)
  );

  always_ff @(posedge i_system_clock) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_head        <= '0;
      r_tail        <= '0;
      r_list_cnt    <= '0;
      r_fresh_ptr   <= '0;
      r_bitmap      <= '0;
      r_alloc_ack   <= 1'b0;
      r_alloc_ptr   <= '0;
      r_alloc_fail  <= 1'b0;
      r_dealloc_ack <= 1'b0;
      r_dealloc_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.dealloc_req) begin
            r_dealloc_ack <= 1'b1;
            r_state       <= ST_ACK_DEALLOC;
            if (!w_dealloc_ok) begin
              r_dealloc_err <= 1'b1;
            end else begin
              r_dealloc_err                <= 1'b0;
              r_bitmap[bus.dealloc_ptr]    <= 1'b0;
              r_tail                       <= bus.dealloc_ptr;
              r_list_cnt                   <= r_list_cnt + ONE_C;
              if (r_list_cnt == '0) begin
                r_head <= bus.dealloc_ptr;
              end
            end
          end else if (bus.alloc_req) begin
            r_alloc_ack <= 1'b1;
            r_state     <= ST_ACK_ALLOC;
            if (r_list_cnt != '0) begin
              // Reuse the oldest returned index.
              r_alloc_ptr      <= r_head;
              r_alloc_fail     <= 1'b0;
              r_head           <= w_nm_rdata;
              r_list_cnt       <= r_list_cnt - ONE_C;
              r_bitmap[r_head] <= 1'b1;
            end else if (r_fresh_ptr < DEPTH_C) begin
              r_alloc_ptr                        <= r_fresh_ptr[PTR_W-1:0];
              r_alloc_fail                       <= 1'b0;
              r_fresh_ptr                        <= r_fresh_ptr + ONE_C;
              r_bitmap[r_fresh_ptr[PTR_W-1:0]]   <= 1'b1;
            end else begin
              r_alloc_ptr  <= '0;
              r_alloc_fail <= 1'b1;
            end
          end
        end

        ST_ACK_ALLOC: begin
          if (!bus.alloc_req) begin
            r_alloc_ack <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        ST_ACK_DEALLOC: begin
          if (!bus.dealloc_req) begin
            r_dealloc_ack <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end

        default: begin
          r_alloc_ack   <= 1'b0;
          r_dealloc_ack <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_free_count = (DEPTH_C - r_fresh_ptr) + r_list_cnt;

  assign bus.alloc_ack   = r_alloc_ack;
  assign bus.alloc_ptr   = r_alloc_ptr;
  assign bus.alloc_fail  = r_alloc_fail;
  assign bus.dealloc_ack = r_dealloc_ack;
  assign bus.dealloc_err = r_dealloc_err;
  assign bus.free_count  = w_free_count;
  assign bus.pool_empty  = (w_free_count == '0);
  assign o_state         = r_state;

  a_free_count_le_depth: assert property (
    @(posedge i_system_clock) disable iff (i_reset) (w_free_count <= DEPTH_C)
  );

endmodule
